// File: rtl/blocking_out_writer.sv
// blocking_out_writer
//
// Producer side of a blocking-port handshake. A command (start, step, count)
// loads an arithmetic sequence. The words are offered one at a time on b_out
// with b_out_notify high. The sequence advances only on a clock edge where the
// consumer also has b_out_sync high.
//
// Optional feature macro: WRITER_TIMEOUT_EN
//   Defined   : a burst that stalls for TIMEOUT consecutive cycles is aborted
//               and err pulses for one cycle.
//   Undefined : the writer waits forever and err is tied low.
//
// Parameters
//   WIDTH   : width of b_out, cmd_start, cmd_step
//   CNT_W   : width of cmd_count
//   TIMEOUT : stall limit in cycles (>= 1). Only used with WRITER_TIMEOUT_EN.
//
// Ports
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   cmd_valid     : command offered
//   cmd_ready     : writer can accept a command (idle)
//   cmd_start     : first word of the sequence
//   cmd_step      : two's-complement increment between words
//   cmd_count     : number of words (0 is legal and completes at once)
//   b_out         : word offered to the consumer
//   b_out_sync    : consumer ready to take b_out
//   b_out_notify  : writer offering b_out
//   busy          : high while a burst is being sent
//   done          : one-cycle pulse when a command completes
//   err           : one-cycle pulse when a burst is aborted by timeout
//
// All outputs are flops, so b_out_sync and cmd_valid have no combinational
// path to any output.
module blocking_out_writer #(
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_step,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] b_out,
  input  logic             b_out_sync,
  output logic             b_out_notify,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // A stall limit of zero would abort before any word could be offered.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("blocking_out_writer: TIMEOUT must be at least 1");
  end

  typedef enum logic [0:0] {
    section_idle = 1'b0,
    section_send = 1'b1
  } section_t;

  section_t         section;
  section_t         nextsection;

  logic [WIDTH-1:0] step;
  logic [CNT_W-1:0] remaining;

  logic [WIDTH-1:0] b_out_next;
  logic             b_out_notify_next;
  logic             cmd_ready_next;
  logic             busy_next;
  logic             done_next;
  logic [WIDTH-1:0] step_next;
  logic [CNT_W-1:0] remaining_next;

  // A word moves only when both sides agree on the same edge; sync alone is
  // meaningless while nothing is offered.
  logic             transfer;
  assign transfer = b_out_notify & b_out_sync;

`ifdef WRITER_TIMEOUT_EN
  // The counter only ever needs to hold 0 .. TIMEOUT-1: the abort fires on
  // the edge that would have taken it to TIMEOUT.
  localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

  logic [STALL_W-1:0] stall_cnt;
  logic [STALL_W-1:0] stall_cnt_next;
  logic               err_q;
  logic               err_next;
`endif

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    nextsection       = section;
    b_out_next        = b_out;
    b_out_notify_next = b_out_notify;
    cmd_ready_next    = cmd_ready;
    busy_next         = busy;
    done_next         = 1'b0;
    step_next         = step;
    remaining_next    = remaining;
`ifdef WRITER_TIMEOUT_EN
    stall_cnt_next    = stall_cnt;
    err_next          = 1'b0;
`endif

    case (section)
      section_idle: begin
        if (cmd_valid) begin
          step_next      = cmd_step;
          remaining_next = cmd_count;
          b_out_next     = cmd_start;
          if (cmd_count != '0) begin
            b_out_notify_next = 1'b1;
            cmd_ready_next    = 1'b0;
            busy_next         = 1'b1;
            nextsection       = section_send;
`ifdef WRITER_TIMEOUT_EN
            stall_cnt_next    = '0;
`endif
          end else begin
            // Empty command: complete immediately, stay ready.
            done_next = 1'b1;
          end
        end
      end

      section_send: begin
        if (transfer) begin
`ifdef WRITER_TIMEOUT_EN
          stall_cnt_next = '0;
`endif
          remaining_next = remaining - 1'b1;
          if (remaining > CNT_W'(1)) begin
            // Modulo-2^WIDTH add; overflow wraps by design.
            b_out_next = b_out + step;
          end else begin
            // Last word taken: b_out keeps it, handshake closes.
            b_out_notify_next = 1'b0;
            cmd_ready_next    = 1'b1;
            busy_next         = 1'b0;
            done_next         = 1'b1;
            nextsection       = section_idle;
          end
        end
`ifdef WRITER_TIMEOUT_EN
        else if (stall_cnt == STALL_LAST) begin
          // Stall limit reached with no transfer on this edge: abandon the
          // rest of the burst without signalling completion.
          b_out_notify_next = 1'b0;
          cmd_ready_next    = 1'b1;
          busy_next         = 1'b0;
          err_next          = 1'b1;
          nextsection       = section_idle;
        end else begin
          stall_cnt_next = stall_cnt + 1'b1;
        end
`endif
      end

      default: begin
        nextsection = section_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section      <= section_idle;
      b_out        <= '0;
      b_out_notify <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      step         <= '0;
      remaining    <= '0;
    end else begin
      section      <= nextsection;
      b_out        <= b_out_next;
      b_out_notify <= b_out_notify_next;
      cmd_ready    <= cmd_ready_next;
      busy         <= busy_next;
      done         <= done_next;
      step         <= step_next;
      remaining    <= remaining_next;
    end
  end

`ifdef WRITER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      err_q     <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      err_q     <= err_next;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_blocking_out_writer.sv
module tb_blocking_out_writer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_step;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] b_out;
  logic             b_out_sync;
  logic             b_out_notify;
  logic             busy;
  logic             done;
  logic             err;

  int tests = 0;
  int fails = 0;

  blocking_out_writer #(
    .WIDTH  (WIDTH),
    .CNT_W  (CNT_W),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_start   (cmd_start),
    .cmd_step    (cmd_step),
    .cmd_count   (cmd_count),
    .b_out       (b_out),
    .b_out_sync  (b_out_sync),
    .b_out_notify(b_out_notify),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: a burst is "word k of start + k*step", k counting the
  // transfers seen so far. Expected outputs follow directly from it.
  // --------------------------------------------------------------------------
  logic             m_sending;
  logic [WIDTH-1:0] m_start;
  logic [WIDTH-1:0] m_step;
  logic [WIDTH-1:0] m_word;
  int               m_count;
  int               m_k;
  int               m_stall;
  logic             m_done;
  logic             m_err;

  task automatic model_reset();
    m_sending = 1'b0;
    m_start   = '0;
    m_step    = '0;
    m_word    = '0;
    m_count   = 0;
    m_k       = 0;
    m_stall   = 0;
    m_done    = 1'b0;
    m_err     = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    logic nd;
    logic ne;
    nd = 1'b0;
    ne = 1'b0;
    if (!m_sending) begin
      if (cmd_valid) begin
        m_start = cmd_start;
        m_step  = cmd_step;
        m_count = int'(cmd_count);
        m_k     = 0;
        m_word  = cmd_start;
        m_stall = 0;
        if (m_count != 0) m_sending = 1'b1;
        else nd = 1'b1;
      end
    end else if (b_out_sync) begin
      m_k     = m_k + 1;
      m_stall = 0;
      if (m_k == m_count) begin
        m_sending = 1'b0;
        nd        = 1'b1;
      end else begin
        m_word = m_start + m_step * WIDTH'(m_k);
      end
    end else begin
`ifdef WRITER_TIMEOUT_EN
      m_stall = m_stall + 1;
      if (m_stall == TO) begin
        m_sending = 1'b0;
        ne        = 1'b1;
      end
`endif
    end
    m_done = nd;
    m_err  = ne;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [WIDTH+4:0] exp_vec();
    return {m_sending, m_sending, ~m_sending, m_done, m_err, m_word};
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_reset();
    // Outputs while reset is held from power-up.
    tests++;
    if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_hold: got %h want %h", {b_out_notify, busy, cmd_ready, done, err, b_out},
               {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    rst = 1'b0;
    model_reset();
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end

    // Start a long burst, take a few words, then reset in the middle.
    cmd_valid = 1'b1; cmd_start = 32'd100; cmd_step = 32'd7; cmd_count = 16'd10; b_out_sync = 1'b1;
    $display("[TB] reset: cmd start=%0d step=%0d count=%0d", cmd_start, cmd_step, cmd_count);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    tests++;
    if ({b_out_notify, b_out} !== {1'b1, 32'd121}) begin
      fails++;
      $display("FAIL reset_pre_burst: got %h want %h", {b_out_notify, b_out}, {1'b1, 32'd121});
    end
    rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
      fails++;
      $display("FAIL reset_async: got %h want %h", {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();
    tests++;
    if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL reset_after_burst: got %h want %h", {b_out_notify, busy, cmd_ready, done, err, b_out},
               {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic();
    logic [WIDTH-1:0] words[$];
    logic [WIDTH-1:0] want[4];
    int dones;
    want = '{32'd5, 32'd8, 32'd11, 32'd14};
    dones = 0;
    cmd_valid = 1'b1; cmd_start = 32'd5; cmd_step = 32'd3; cmd_count = 16'd4; b_out_sync = 1'b1;
    $display("[TB] basic: cmd start=%0d step=%0d count=%0d", cmd_start, cmd_step, cmd_count);
    for (int c = 0; c < 7; c++) begin
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL basic_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (b_out_notify && b_out_sync) words.push_back(b_out);
      if (done) dones++;
      tick();
      cmd_valid = 1'b0;
    end
    tests++;
    if (words.size() != 4 || dones != 1) begin
      fails++;
      $display("FAIL basic_counts: got words=%0d done=%0d want words=4 done=1", words.size(), dones);
    end
    for (int i = 0; i < 4 && i < words.size(); i++) begin
      tests++;
      if (words[i] !== want[i]) begin
        fails++;
        $display("FAIL basic_word%0d: got %0d want %0d", i, words[i], want[i]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall();
    logic pat[6];
    logic [WIDTH-1:0] words[$];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    cmd_valid = 1'b1; cmd_start = 32'd0; cmd_step = 32'd1; cmd_count = 16'd3; b_out_sync = 1'b0;
    $display("[TB] stall: cmd start=%0d step=%0d count=%0d", cmd_start, cmd_step, cmd_count);
    for (int c = 0; c < 9; c++) begin
      b_out_sync = (c >= 1 && c <= 6) ? pat[c-1] : 1'b0;
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL stall_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (b_out_notify && b_out_sync) words.push_back(b_out);
      tick();
      cmd_valid = 1'b0;
    end
    tests++;
    if (words.size() != 3) begin
      fails++;
      $display("FAIL stall_transfers: got %0d want 3", words.size());
    end
    for (int i = 0; i < 3 && i < words.size(); i++) begin
      tests++;
      if (words[i] !== WIDTH'(i)) begin
        fails++;
        $display("FAIL stall_word%0d: got %0d want %0d", i, words[i], i);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap();
    logic [WIDTH-1:0] words[$];
    logic [WIDTH-1:0] want[6];
    logic [WIDTH-1:0] starts[2];
    logic [WIDTH-1:0] steps[2];
    want   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'd10, 32'd9, 32'd8};
    starts = '{32'hFFFF_FFFE, 32'd10};
    steps  = '{32'd1, 32'hFFFF_FFFF};
    for (int s = 0; s < 2; s++) begin
      cmd_valid = 1'b1; cmd_start = starts[s]; cmd_step = steps[s]; cmd_count = 16'd3; b_out_sync = 1'b1;
      $display("[TB] wrap: cmd start=%h step=%h count=%0d", cmd_start, cmd_step, cmd_count);
      for (int c = 0; c < 5; c++) begin
        tests++;
        if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
          fails++;
          $display("FAIL wrap%0d_cycle%0d: got %h want %h", s, c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
        end
        if (b_out_notify && b_out_sync) words.push_back(b_out);
        tick();
        cmd_valid = 1'b0;
      end
    end
    tests++;
    if (words.size() != 6) begin
      fails++;
      $display("FAIL wrap_transfers: got %0d want 6", words.size());
    end
    for (int i = 0; i < 6 && i < words.size(); i++) begin
      tests++;
      if (words[i] !== want[i]) begin
        fails++;
        $display("FAIL wrap_word%0d: got %h want %h", i, words[i], want[i]);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_start = 32'd55; cmd_step = 32'd1; cmd_count = 16'd0; b_out_sync = 1'b1;
    $display("[TB] back_to_back: cmd start=%0d count=0", cmd_start);
    for (int c = 0; c < 7; c++) begin
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (c == 1) begin
        tests++;
        if ({done, cmd_ready, b_out_notify} !== 3'b110) begin
          fails++;
          $display("FAIL b2b_zero_done: got done,ready,notify=%b want 110", {done, cmd_ready, b_out_notify});
        end
        // Next command offered in the done cycle itself.
        cmd_valid = 1'b1; cmd_start = 32'd7; cmd_step = 32'd2; cmd_count = 16'd2;
        $display("[TB] back_to_back: cmd start=%0d step=%0d count=%0d", cmd_start, cmd_step, cmd_count);
      end
      if (c == 2) begin
        tests++;
        if ({b_out_notify, b_out} !== {1'b1, 32'd7}) begin
          fails++;
          $display("FAIL b2b_no_gap: got %h want %h", {b_out_notify, b_out}, {1'b1, 32'd7});
        end
      end
      if (c == 4) begin
        tests++;
        if ({done, cmd_ready} !== 2'b11) begin
          fails++;
          $display("FAIL b2b_second_done: got done,ready=%b want 11", {done, cmd_ready});
        end
      end
      tick();
      if (c != 1 && c != 0) cmd_valid = 1'b0;
      if (c == 0) cmd_valid = 1'b0;
    end
  endtask

  // --------------------------------------------------------------------------
`ifdef WRITER_TIMEOUT_EN
  task automatic test_timeout();
    int errs, dones, highs;
    errs = 0; dones = 0; highs = 0;
    cmd_valid = 1'b1; cmd_start = 32'd9; cmd_step = 32'd1; cmd_count = 16'd3; b_out_sync = 1'b0;
    $display("[TB] timeout: cmd start=%0d count=%0d sync held 0", cmd_start, cmd_count);
    for (int c = 0; c < 9; c++) begin
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL timeout_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (err) errs++;
      if (done) dones++;
      if (b_out_notify) highs++;
      tick();
      cmd_valid = 1'b0;
    end
    tests++;
    if (errs != 1 || dones != 0 || highs != TO) begin
      fails++;
      $display("FAIL timeout_abort: got err=%0d done=%0d notify_cycles=%0d want 1 0 %0d", errs, dones, highs, TO);
    end

    errs = 0; dones = 0;
    cmd_valid = 1'b1; cmd_start = 32'd3; cmd_step = 32'd1; cmd_count = 16'd1; b_out_sync = 1'b0;
    $display("[TB] timeout: cmd start=%0d count=%0d sync on 4th stall cycle", cmd_start, cmd_count);
    for (int c = 0; c < 8; c++) begin
      b_out_sync = (c == TO);
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL timeout_late_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (err) errs++;
      if (done) dones++;
      tick();
      cmd_valid = 1'b0;
    end
    tests++;
    if (errs != 0 || dones != 1) begin
      fails++;
      $display("FAIL timeout_transfer_wins: got err=%0d done=%0d want 0 1", errs, dones);
    end
  endtask
`else
  task automatic test_hold();
    int highs;
    highs = 0;
    cmd_valid = 1'b1; cmd_start = 32'd42; cmd_step = 32'd1; cmd_count = 16'd1; b_out_sync = 1'b0;
    $display("[TB] hold: cmd start=%0d count=%0d sync held 0", cmd_start, cmd_count);
    for (int c = 0; c < 24; c++) begin
      b_out_sync = (c == 21);
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL hold_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (b_out_notify && b_out === 32'd42) highs++;
      tick();
      cmd_valid = 1'b0;
    end
    tests++;
    if (highs != 21) begin
      fails++;
      $display("FAIL hold_notify_cycles: got %0d want 21", highs);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  task automatic test_random();
    int words, cmds;
    words = 0; cmds = 0;
    for (int c = 0; c < 400; c++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_start  = $urandom;
      cmd_step   = $urandom;
      cmd_count  = CNT_W'($urandom_range(0, 5));
      b_out_sync = (c >= 390) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (c >= 390) cmd_valid = 1'b0;
      tests++;
      if ({b_out_notify, busy, cmd_ready, done, err, b_out} !== exp_vec()) begin
        fails++;
        $display("FAIL random_cycle%0d: got %h want %h", c, {b_out_notify, busy, cmd_ready, done, err, b_out}, exp_vec());
      end
      if (b_out_notify && b_out_sync) words++;
      if (cmd_ready && cmd_valid) cmds++;
      tick();
    end
    $display("[TB] random: %0d commands, %0d words", cmds, words);
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_start  = '0;
    cmd_step   = '0;
    cmd_count  = '0;
    b_out_sync = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_back_to_back();
`ifdef WRITER_TIMEOUT_EN
    test_timeout();
`else
    test_hold();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blocking_out_writer.md
# blocking_out_writer

Producer end of the blocking-port handshake: it drives a `b_out` / `b_out_sync` / `b_out_notify` triple to a consumer module that reads a blocking input port.
- A command (start, step, count) loads an arithmetic sequence.
- The block offers one word at a time and advances only when the consumer synchronises.
- It sits between a command source and any generated consumer module with a blocking integer input.

## Interface
- `WIDTH`, 32: data width of `b_out`, `cmd_start`, `cmd_step`.
- `CNT_W`, 16: width of `cmd_count`.
- `TIMEOUT`, 255: stall limit in cycles. Used only with `WRITER_TIMEOUT_EN`; must be at least 1.
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_start`, in, WIDTH: first word of the sequence.
- `cmd_step`, in, WIDTH: increment between words, two's complement.
- `cmd_count`, in, CNT_W: number of words to send; 0 is legal.
- `b_out`, out, WIDTH: word offered to the consumer.
- `b_out_sync`, in, 1: consumer ready to take `b_out`.
- `b_out_notify`, out, 1: writer offering `b_out`.
- `busy`, out, 1: high in `section_send`.
- `done`, out, 1: one-cycle pulse when a command completes.
- `err`, out, 1: one-cycle pulse when a burst is aborted by timeout.

## Operation
- Sections: `section_idle` and `section_send`. The block registers `section` and `nextsection` as in generated modules.
- Transfer: a rising edge with `b_out_notify` = 1 and `b_out_sync` = 1. `b_out_sync` is ignored while `b_out_notify` = 0.
- `section_idle`:
  - `cmd_ready` = 1, `b_out_notify` = 0.
  - On `cmd_valid` and `cmd_ready`: latch step, set `remaining` = `cmd_count`, load `b_out` = `cmd_start`.
  - If `cmd_count` ≠ 0: set `b_out_notify` = 1, `cmd_ready` = 0, go to `section_send`.
  - If `cmd_count` = 0: pulse `done` next cycle, stay idle, `cmd_ready` stays 1.
- `section_send`, on each transfer:
  - If `remaining` > 1: `b_out` ← `b_out` + step, modulo 2^WIDTH (wraps silently); `remaining` decrements; `b_out_notify` stays 1.
  - If `remaining` = 1: `b_out_notify` ← 0, `done` ← 1, `cmd_ready` ← 1, return to `section_idle`. `b_out` holds the last word.
- No transfer: `b_out` and `b_out_notify` hold. Data stays stable for as long as notify is high.
- `cmd_valid` is ignored while in `section_send`.
- Reset values: `section` = `nextsection` = `section_idle`, `b_out` = 0, `b_out_notify` = 0, `cmd_ready` = 1, `busy` = 0, `done` = 0, `err` = 0, `remaining` = 0, step = 0.
- Reset mid-burst: all state returns to reset values on assertion. Untransferred words are dropped, and no `done` or `err` pulse is generated.

## Timing
- All outputs are registered; there is no combinational path from `b_out_sync` or `cmd_valid` to any output.
- Command accepted at edge N: `b_out_notify` = 1, `b_out` = start, `busy` = 1 in cycle N+1.
- Throughput: one word per cycle while `b_out_sync` is held high. A count-C command with sync tied high finishes its last transfer at edge N+C.
- `done` is high in the cycle after the last transfer (N+C+1). `cmd_ready` = 1 in the same cycle, so the next command can be accepted at edge N+C+1.
- Count 0 accepted at edge N: `done` = 1 in cycle N+1, `b_out_notify` never rises.

## Configuration
- Macro: `WRITER_TIMEOUT_EN`.
- Defined:
  - A stall counter increments each cycle with notify = 1 and sync = 0, and clears on every transfer and on entry to send.
  - When the counter reaches `TIMEOUT`: `b_out_notify` ← 0, `err` ← 1 for one cycle, `cmd_ready` ← 1, go to `section_idle`. No `done` pulse.
  - If a transfer happens in the same cycle the counter reaches `TIMEOUT`, the transfer wins.
- Undefined: no counter logic is present; the writer waits indefinitely and `err` is tied to 0.

## Test plan
- Reset asserted mid-sequence, then released → all outputs at reset values; `cmd_ready` = 1 one cycle after release.
- start = 5, step = 3, count = 4, `b_out_sync` tied 1 → `b_out` = 5, 8, 11, 14 on four consecutive cycles; `done` pulses once; `cmd_ready` returns the same cycle.
- start = 0, step = 1, count = 3, sync toggling 1-0-0-1-0-1 → exactly three transfers (0, 1, 2); `b_out` stable during each stall.
- start = 0xFFFF_FFFE, step = 1, count = 3 → 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 (wrap); step = 0xFFFF_FFFF gives a descending sequence.
- count = 0 → no notify, `done` one cycle after accept; back-to-back commands accepted at the `done` cycle with no gap.
- With `WRITER_TIMEOUT_EN`, `TIMEOUT` = 4, sync held 0 → notify drops after 4 stall cycles, `err` pulses once, no `done`.
- With `WRITER_TIMEOUT_EN`, `TIMEOUT` = 4, sync rising on the 4th stall cycle → transfer completes, no `err`.
